// File: rtl/mac_pe_sequencer.sv
// mac_pe_sequencer
//   Job-level controller for one binned 4b x 8b MAC processing element.
//   Streams (weight, activation) pairs into the PE, fires its accumulate
//   phase, waits for the result, parks it in a one-entry valid/ready slot,
//   then clears the PE for the next dot product.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_len                    pairs per job (0 = 2^LEN_W), sampled on first accept
//   abort                      synchronous job drop
//   in_valid/in_ready          operand pair handshake; in_weight, in_act operands
//   mac_en, mac_data_valid,
//   mac_weight, mac_activation,
//   mac_reset, mac_acc         PE control / data
//   mac_output_valid,
//   mac_output_result          PE result
//   res_valid/res_ready,
//   res_data                   result slot
//   busy                       job in progress
//   err                        sticky drain timeout flag
//
// Optional feature (macro MAC_SEQ_ZERO_STAT_EN)
//   zero_cnt       running count of accepted zero-weight/zero-activation pairs
//   zero_cnt_last  zero_cnt captured together with the job result

module mac_pe_sequencer #(
    parameter int unsigned LEN_W = 10,
    parameter int unsigned RES_W = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_weight,
    input  logic [7:0]       in_act,
    output logic             mac_en,
    output logic             mac_data_valid,
    output logic [3:0]       mac_weight,
    output logic [7:0]       mac_activation,
    output logic             mac_reset,
    output logic             mac_acc,
    input  logic             mac_output_valid,
    input  logic [RES_W-1:0] mac_output_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [RES_W-1:0] res_data,
    output logic             busy,
`ifdef MAC_SEQ_ZERO_STAT_EN
    output logic [LEN_W-1:0] zero_cnt,
    output logic [LEN_W-1:0] zero_cnt_last,
`endif
    output logic             err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACC,
        ST_DRAIN,
        ST_CLEAR
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic             res_valid_q, res_valid_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic             err_q, err_d;
    logic             slot_free;
    logic             capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        dcnt_d      = dcnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        err_d       = err_q;
        in_ready    = 1'b0;
        mac_en      = 1'b1;
        mac_acc     = 1'b0;
        mac_reset   = 1'b0;
        capture     = 1'b0;

        slot_free = !res_valid_q || res_ready;

        // Pop first; a capture later in this block overrides it (refill wins).
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                in_ready = !abort;
                if (in_valid && !abort) begin
                    len_d   = cfg_len;
                    cnt_d   = LEN_W'(1);
                    state_d = (cfg_len == LEN_W'(1)) ? ST_ACC : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        cnt_d = cnt_q + LEN_W'(1);
                        // len_q == 0 wraps to all-ones, giving 2^LEN_W pairs.
                        if (cnt_q == len_q - LEN_W'(1)) begin
                            state_d = ST_ACC;
                        end
                    end
                end
            end
            ST_ACC: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else begin
                    mac_acc = 1'b1;
                    dcnt_d  = '0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d = ST_CLEAR;
                end else if (mac_output_valid) begin
                    if (slot_free) begin
                        capture     = 1'b1;
                        res_valid_d = 1'b1;
                        res_data_d  = mac_output_result;
                        dcnt_d      = dcnt_q + 4'd1;
                        state_d     = ST_CLEAR;
                    end else begin
                        // Freeze the PE so it holds its result until the slot frees.
                        mac_en = 1'b0;
                    end
                end else begin
                    dcnt_d = dcnt_q + 4'd1;
                    if (dcnt_q == 4'd7) begin
                        err_d   = 1'b1;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                mac_reset = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mac_data_valid = in_valid && in_ready;
    assign mac_weight     = in_weight;
    assign mac_activation = in_act;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;

`ifdef MAC_SEQ_ZERO_STAT_EN
    logic [LEN_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [LEN_W-1:0] zero_cnt_last_q, zero_cnt_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q      <= '0;
            zero_cnt_last_q <= '0;
        end else begin
            zero_cnt_q      <= zero_cnt_d;
            zero_cnt_last_q <= zero_cnt_last_d;
        end
    end

    always_comb begin
        zero_cnt_d      = zero_cnt_q;
        zero_cnt_last_d = zero_cnt_last_q;
        if (state_q == ST_CLEAR) begin
            zero_cnt_d = '0;
        end else if (mac_data_valid && (in_weight == 4'd0 || in_act == 8'd0)) begin
            zero_cnt_d = zero_cnt_q + LEN_W'(1);
        end
        if (capture) begin
            zero_cnt_last_d = zero_cnt_q;
        end
    end

    assign zero_cnt      = zero_cnt_q;
    assign zero_cnt_last = zero_cnt_last_q;
`endif

endmodule

// File: doc/mac_pe_sequencer.md
Name: mac_pe_sequencer

Overview:
- Job-level controller for one 4b-weight × 8b-activation binned MAC processing element (the PE with 8 weight-indexed partial accumulators and an 8-cycle multiply-out phase).
- Accepts a stream of (weight, activation) pairs, forwards them to the PE, then fires the PE's acc phase and waits for its result.
- Captures the result into a one-entry valid/ready output slot, then clears the PE for the next dot product.
- Sits between the operand fetch/buffer logic and the PE; one instance per PE.

Parameters:
- LEN_W, 10, width of the job length (pairs per dot product).
- RES_W, 21, width of the PE result and res_data.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_len  in  LEN_W  pairs per job; sampled on the first accepted pair of a job; 0 means 2^LEN_W.
- abort  in  1  synchronous job drop, level-sampled each cycle.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- in_weight  in  4  signed weight.
- in_act  in  8  signed activation.
- mac_en  out  1  PE enable.
- mac_data_valid  out  1  PE data_valid.
- mac_weight  out  4  PE weight (= in_weight, combinational).
- mac_activation  out  8  PE activation (= in_act, combinational).
- mac_reset  out  1  PE synchronous clear.
- mac_acc  out  1  PE accumulate-start pulse.
- mac_output_valid  in  1  PE output_valid.
- mac_output_result  in  RES_W  PE signed result.
- res_valid  out  1  result slot full.
- res_ready  in  1  result consumer ready.
- res_data  out  RES_W  signed dot-product result.
- busy  out  1  state != IDLE.
- err  out  1  sticky; set on drain timeout; cleared only by rst_n.

Behaviour:
- States: IDLE, LOAD, ACC, DRAIN, CLEAR.
- Reset values: state IDLE; in_ready 1; busy 0; err 0; res_valid 0; res_data 0; mac_acc 0; mac_reset 0; mac_data_valid 0; mac_en 1; counters 0. The PE shares rst_n.
- Pair forwarding:
  - mac_data_valid = in_valid & in_ready.
  - in_ready = 1 only in IDLE and LOAD, and only when abort = 0.
  - Pairs are forwarded in the same cycle with no registering. Zero weight or activation pairs are still forwarded; the PE skips them.
- IDLE:
  - On accept: latch len = cfg_len and set cnt = 1.
  - Next state is ACC if len == 1, else LOAD.
- LOAD:
  - Each accept increments cnt.
  - The accept with cnt == len-1 (mod 2^LEN_W) is the last pair; go to ACC.
  - in_valid low: hold state, mac_data_valid 0.
- ACC:
  - mac_acc = 1 for exactly this one cycle, with mac_data_valid 0.
  - Clear drain counter dcnt; go to DRAIN.
- DRAIN:
  - dcnt increments each cycle while mac_en = 1.
  - mac_output_valid is required in the 8th cycle after the ACC cycle (dcnt == 7).
  - If mac_output_valid = 1 and the slot is free (res_valid == 0 or res_ready == 1): res_data <= mac_output_result, res_valid <= 1, go to CLEAR.
  - If mac_output_valid = 1 and the slot is full: mac_en = 0, freezing the PE and holding output_valid/result; stay in DRAIN until the slot frees.
  - If dcnt reaches 8 without mac_output_valid: set err and go to CLEAR; no result is produced.
- CLEAR:
  - mac_reset = 1 for one cycle, with mac_data_valid = 0 and mac_acc = 0. This zeroes the PE bins, result and output_valid.
  - Go to IDLE.
- Result slot:
  - res_valid falls the cycle after res_valid & res_ready, unless it is refilled in that same cycle (refill wins).
  - res_data is stable while res_valid & ~res_ready.
- abort:
  - In LOAD, ACC or DRAIN: go to CLEAR next cycle; the job result is discarded and the result slot is untouched.
  - In IDLE or CLEAR: no effect.
  - Abort takes priority over accept and over capture in the same cycle.
- mac_en = 1 in every state except the DRAIN stall case.
- mac_acc is only ever asserted with all PE bins loaded and the PE's output counter at 0, which is guaranteed by ACC following LOAD after CLEAR/reset.
- Throughput: a job of N pairs occupies N + 1 (ACC) + 8 (DRAIN) + 1 (CLEAR) cycles with no stalls.
- rst_n mid-job: immediate return to reset values; any partial job is lost.

Optional Feature:
- Macro: MAC_SEQ_ZERO_STAT_EN.
- When defined:
  - Adds output zero_cnt [LEN_W-1:0], which counts accepted pairs of the current job with weight == 0 or activation == 0.
  - Its value is latched into zero_cnt_last [LEN_W-1:0] (also an output) on result capture. Both reset to 0.
  - The running count clears in CLEAR.
- When undefined: neither port nor any counter logic exists.

Test Plan:
- Single job: cfg_len=3; pairs (3,10), (-2,5), (3,-4) back-to-back -> mac_acc pulses 1 cycle after the last accept; res_valid rises 9 cycles after the mac_acc cycle; res_data = 8; mac_reset pulses once; busy drops.
- cfg_len=1, pair (-8,127) -> next state ACC; res_data = -1016.
- Backpressure: res_ready=0 with the first result held, then a second job (cfg_len=2, (1,1), (1,1)) -> mac_en=0 while mac_output_valid=1; after res_ready=1 the first result (8) is popped, then res_data = 2 and mac_en returns to 1.
- in_valid gaps and zero pairs: cfg_len=4; pairs (0,9), (5,0), (7,2), (-1,3) with idle cycles between -> res_data = 11. With MAC_SEQ_ZERO_STAT_EN defined, zero_cnt_last = 2.
- Abort in LOAD after 2 of 4 pairs -> CLEAR next cycle, no res_valid. The next job (cfg_len=1, (2,3)) gives res_data = 6, proving the PE was cleared.
- Timeout: force mac_output_valid=0 -> err=1 at dcnt 8, CLEAR entered, no result; rst_n low mid-LOAD -> all outputs return to reset values immediately.
